// File: rtl/commit_ring_ctrl_if.sv
// Bus between the rename/execute side and the commit-ring controller.
// The master drives allocation, completion and flush requests; the slave
// (the controller) returns the ring position and retirement feedback.
interface commit_ring_ctrl_if #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5
);
    logic [LNCOMMIT:0]   alloc_count;
    logic [NCOMMIT-1:0]  complete;
    logic                flush;
    logic [LNCOMMIT-1:0] flush_addr;

    logic [LNCOMMIT-1:0] next_start;
    logic [LNCOMMIT-1:0] current_start;
    logic [LNCOMMIT:0]   current_available;
    logic [NCOMMIT-1:0]  commit_done;
    logic [NCOMMIT-1:0]  commit_reg;
    logic [3:0]          commit_count;
    logic                empty;

    modport master (
        output alloc_count, complete, flush, flush_addr,
        input  next_start, current_start, current_available,
               commit_done, commit_reg, commit_count, empty
    );

    modport slave (
        input  alloc_count, complete, flush, flush_addr,
        output next_start, current_start, current_available,
               commit_done, commit_reg, commit_count, empty
    );
endinterface

// File: rtl/commit_ring_ctrl.sv
// Retire-side controller for the circular commit-station ring.
// Tracks head/tail/count plus per-entry valid and done flags, retires up to
// NRETIRE completed entries per clock in program order, and trims the ring
// back to a flushing branch. All outputs come from registered state only.
module commit_ring_ctrl #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int NRETIRE  = 4
) (
    input logic               clk,
    input logic               reset,
    commit_ring_ctrl_if.slave bus
);
    typedef logic [LNCOMMIT-1:0] idx_t;
    typedef logic [LNCOMMIT:0]   cnt_t;

    localparam cnt_t RING_SIZE = cnt_t'(NCOMMIT);

    idx_t               head_q, head_d;
    idx_t               tail_q, tail_d;
    cnt_t               count_q, count_d;
    logic [NCOMMIT-1:0] valid_q, valid_d;
    logic [NCOMMIT-1:0] done_q, done_d;

    logic [NCOMMIT-1:0] commit_mask;
    logic [3:0]         n_retire;
    logic               chain;
    idx_t               walk_idx;

    cnt_t               available;
    logic               flush_hit;
    logic               alloc_ok;
    idx_t               keep_span;

    assign available = RING_SIZE - count_q;
    assign flush_hit = bus.flush && valid_q[bus.flush_addr];
    assign alloc_ok  = (bus.alloc_count != '0) && !bus.flush && (bus.alloc_count <= available);
    // Distance from head to the flushing branch; entries further out are younger.
    assign keep_span = bus.flush_addr - head_q;

    // In-order retire walk: stop at the first entry that is not valid and done.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        commit_mask = '0;
        n_retire    = '0;
        chain       = 1'b1;
        walk_idx    = head_q;
        for (int i = 0; i < NRETIRE; i++) begin
            walk_idx = head_q + idx_t'(i);
            if (chain && valid_q[walk_idx] && done_q[walk_idx]) begin
                commit_mask[walk_idx] = 1'b1;
                n_retire              = n_retire + 4'd1;
            end else begin
                chain = 1'b0;
            end
        end
    end

    // Next-state: completion, retirement, then either flush trim or allocation.
    always_comb begin
        // Completions only land on live entries; retired entries are freed.
        done_d  = (done_q | (bus.complete & valid_q)) & ~commit_mask;
        valid_d = valid_q & ~commit_mask;
        head_d  = head_q + idx_t'(n_retire);
        tail_d  = tail_q;
        count_d = count_q - cnt_t'(n_retire);

        if (flush_hit) begin
            for (int i = 0; i < NCOMMIT; i++) begin
                if (idx_t'(idx_t'(i) - head_q) > keep_span) begin
                    valid_d[i] = 1'b0;
                    done_d[i]  = 1'b0;
                end
            end
            tail_d  = bus.flush_addr + idx_t'(1);
            count_d = {1'b0, keep_span} + cnt_t'(1) - cnt_t'(n_retire);
        end else if (alloc_ok) begin
            // Allocated stations are currently free, so no retire/complete overlap.
            for (int i = 0; i < NCOMMIT; i++) begin
                if ({1'b0, idx_t'(idx_t'(i) - tail_q)} < bus.alloc_count) begin
                    valid_d[i] = 1'b1;
                    done_d[i]  = 1'b0;
                end
            end
            tail_d  = tail_q + bus.alloc_count[LNCOMMIT-1:0];
            count_d = count_q - cnt_t'(n_retire) + bus.alloc_count;
        end
    end

    // State register with synchronous reset that overrides every input.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the per-entry flags are control state and must reset, unlike a payload RAM.
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.next_start        = tail_q;
    assign bus.current_start     = head_q;
    assign bus.current_available = available;
    assign bus.commit_done       = commit_mask;
    assign bus.commit_reg        = commit_mask;
    assign bus.commit_count      = n_retire;
    assign bus.empty             = (count_q == '0);
endmodule

// File: tb/tb_commit_ring_ctrl.sv
// Directed self-checking bench for commit_ring_ctrl. Inputs change 1 time
// unit after the rising edge; outputs are registered-state derived, so they
// are checked mid-cycle before the next edge.
module tb_commit_ring_ctrl;
    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int NRETIRE  = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    commit_ring_ctrl_if #(.NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT)) bus ();

    commit_ring_ctrl #(
        .NCOMMIT (NCOMMIT),
        .LNCOMMIT(LNCOMMIT),
        .NRETIRE (NRETIRE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_count = '0;
        bus.complete    = '0;
        bus.flush       = 1'b0;
        bus.flush_addr  = '0;
    endtask

    // Absolute watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state.
        check("rst_next_start", 32'(bus.next_start), 32'd0);
        check("rst_cur_start",  32'(bus.current_start), 32'd0);
        check("rst_avail",      32'(bus.current_available), 32'd32);
        check("rst_commit_done", bus.commit_done, 32'h0);
        check("rst_commit_reg",  bus.commit_reg, 32'h0);
        check("rst_commit_cnt", 32'(bus.commit_count), 32'd0);
        check("rst_empty",      32'(bus.empty), 32'd1);

        // Allocate 4 entries.
        bus.alloc_count = 6'd4;
        tick();
        idle();
        check("alloc4_next_start", 32'(bus.next_start), 32'd4);
        check("alloc4_avail",      32'(bus.current_available), 32'd28);
        check("alloc4_empty",      32'(bus.empty), 32'd0);
        check("alloc4_commit",     bus.commit_done, 32'h0);

        // Complete 2,3 out of order: head not done, nothing retires.
        bus.complete = 32'hC;
        tick();
        idle();
        check("ooo_no_retire", bus.commit_done, 32'h0);

        // Complete 0: no zero-cycle retire, then retires alone next cycle.
        bus.complete = 32'h1;
        check("zero_cycle_block", bus.commit_done, 32'h0);
        tick();
        idle();
        check("head_retire_mask", bus.commit_done, 32'h1);
        check("head_retire_cnt",  32'(bus.commit_count), 32'd1);

        // Complete 1 in the same cycle 0 retires; 1,2,3 retire together next.
        bus.complete = 32'h2;
        tick();
        idle();
        check("burst_mask",      bus.commit_done, 32'hE);
        check("burst_reg",       bus.commit_reg, 32'hE);
        check("burst_cnt",       32'(bus.commit_count), 32'd3);
        check("burst_cur_start", 32'(bus.current_start), 32'd1);
        tick();
        check("burst_empty",     32'(bus.empty), 32'd1);
        check("burst_head",      32'(bus.current_start), 32'd4);

        // Move head/tail to 30: allocate 4..29, complete all, drain.
        bus.alloc_count = 6'd26;
        tick();
        idle();
        bus.complete = 32'h3FFF_FFF0;
        tick();
        idle();
        check("cap_mask", bus.commit_done, 32'h0000_00F0);
        check("cap_cnt",  32'(bus.commit_count), 32'd4);
        for (int k = 0; k < 12 && !bus.empty; k++) tick();
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_head",  32'(bus.current_start), 32'd30);
        check("drain_tail",  32'(bus.next_start), 32'd30);

        // Wrap-around allocation 30,31,0,1 retired in one clock.
        bus.alloc_count = 6'd4;
        tick();
        idle();
        check("wrap_next_start", 32'(bus.next_start), 32'd2);
        check("wrap_avail",      32'(bus.current_available), 32'd28);
        bus.complete = 32'hC000_0003;
        tick();
        idle();
        check("wrap_mask", bus.commit_done, 32'hC000_0003);
        check("wrap_cnt",  32'(bus.commit_count), 32'd4);
        tick();
        check("wrap_empty", 32'(bus.empty), 32'd1);
        check("wrap_head",  32'(bus.current_start), 32'd2);

        // Full ring: allocate 32, then an over-allocation is dropped.
        bus.alloc_count = 6'd32;
        tick();
        idle();
        check("full_avail",      32'(bus.current_available), 32'd0);
        check("full_next_start", 32'(bus.next_start), 32'd2);
        check("full_empty",      32'(bus.empty), 32'd0);
        bus.alloc_count = 6'd1;
        tick();
        idle();
        check("drop_next_start", 32'(bus.next_start), 32'd2);
        check("drop_avail",      32'(bus.current_available), 32'd0);

        // Retire one; the freed slot is not usable by the same-cycle allocation.
        bus.complete = 32'h4;
        tick();
        idle();
        check("full_retire_mask", bus.commit_done, 32'h4);
        bus.alloc_count = 6'd1;
        tick();
        idle();
        check("freed_avail",      32'(bus.current_available), 32'd1);
        check("freed_next_start", 32'(bus.next_start), 32'd2);
        check("freed_head",       32'(bus.current_start), 32'd3);

        // Reset wins over a concurrent allocation.
        reset = 1'b1;
        bus.alloc_count = 6'd5;
        tick();
        reset = 1'b0;
        idle();
        check("midrst_avail",      32'(bus.current_available), 32'd32);
        check("midrst_next_start", 32'(bus.next_start), 32'd0);

        // Flush at 5 with entries 0..9 live and a concurrent allocation.
        bus.alloc_count = 6'd10;
        tick();
        idle();
        bus.flush       = 1'b1;
        bus.flush_addr  = 5'd5;
        bus.alloc_count = 6'd3;
        tick();
        idle();
        check("flush_next_start", 32'(bus.next_start), 32'd6);
        check("flush_avail",      32'(bus.current_available), 32'd26);
        check("flush_head",       32'(bus.current_start), 32'd0);
        bus.complete = 32'h3FF;
        tick();
        idle();
        check("flush_ret1_mask", bus.commit_done, 32'hF);
        tick();
        check("flush_ret2_mask", bus.commit_done, 32'h30);
        check("flush_ret2_cnt",  32'(bus.commit_count), 32'd2);
        tick();
        check("flush_drain_empty", 32'(bus.empty), 32'd1);
        check("flush_drain_head",  32'(bus.current_start), 32'd6);

        // Flush in the same cycle as entries 0,1 retire.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.alloc_count = 6'd10;
        tick();
        idle();
        bus.complete = 32'h3;
        tick();
        idle();
        bus.flush      = 1'b1;
        bus.flush_addr = 5'd5;
        check("fr_cnt", 32'(bus.commit_count), 32'd2);
        tick();
        idle();
        check("fr_head",       32'(bus.current_start), 32'd2);
        check("fr_next_start", 32'(bus.next_start), 32'd6);
        check("fr_avail",      32'(bus.current_available), 32'd28);

        // Flush of an invalid entry is ignored, and so is its allocation.
        bus.flush       = 1'b1;
        bus.flush_addr  = 5'd20;
        bus.alloc_count = 6'd2;
        tick();
        idle();
        check("badflush_next_start", 32'(bus.next_start), 32'd6);
        check("badflush_avail",      32'(bus.current_available), 32'd28);

        // Surviving entries 2..5 still retire together.
        bus.complete = 32'h3C;
        tick();
        idle();
        check("survive_mask", bus.commit_done, 32'h3C);
        check("survive_cnt",  32'(bus.commit_count), 32'd4);
        tick();
        check("survive_empty", 32'(bus.empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/commit_ring_ctrl.md
Name: commit_ring_ctrl

Overview:
- Retire-side controller for the circular commit-station ring that the rename stage allocates into.
- Tracks head (oldest), tail (next allocation) and per-entry valid/done state.
- Retires completed entries in program order, up to NRETIRE per clock, and trims the ring on a branch flush.
- Drives the feedback rename consumes: current_available, next_start, and the commit_done / commit_reg vectors used by rename and the scoreboards.

Parameters:
- NCOMMIT, 32, number of commit stations (power of two).
- LNCOMMIT, 5, log2(NCOMMIT).
- NRETIRE, 4, maximum entries retired per clock (1..8).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alloc_count  in  LNCOMMIT+1  entries rename allocates this clock (0..NCOMMIT)
- complete  in  NCOMMIT  per-entry completion pulses from execution units
- flush  in  1  mispredict/trap flush
- flush_addr  in  LNCOMMIT  entry of the flushing branch; it is kept, everything younger is discarded
- next_start  out  LNCOMMIT  tail index; first station of the next allocation
- current_start  out  LNCOMMIT  head index (oldest live entry)
- current_available  out  LNCOMMIT+1  free stations = NCOMMIT-count
- commit_done  out  NCOMMIT  one-hot-per-entry mask of stations retiring this clock
- commit_reg  out  NCOMMIT  identical copy of commit_done, for scoreboard fan-out
- commit_count  out  4  number of entries retiring this clock
- empty  out  1  count==0

Behaviour:
- State:
  - r_head and r_tail, LNCOMMIT bits each, modulo NCOMMIT.
  - r_count, 0..NCOMMIT.
  - r_valid[NCOMMIT] and r_done[NCOMMIT].
  - Full vs empty (head==tail in both cases) is resolved by r_count only.
- Reset: head=tail=0, count=0, all valid/done=0. Outputs: current_available=NCOMMIT, commit_done=commit_reg=0, commit_count=0, empty=1, next_start=current_start=0.
- Retire (combinational from registered state):
  - Walk i=0..NRETIRE-1 from head.
  - Entry head+i retires iff it is valid, done, and all earlier walked entries retire.
  - commit_done bit set for each retiring entry; commit_count = number retiring.
  - At the clock edge: head += commit_count; valid/done cleared for retired entries.
- Complete:
  - complete[i] sets r_done[i] at the next edge only if r_valid[i] (pre-edge) is set; otherwise ignored.
  - A completion is first retire-eligible the cycle after it is presented (zero-cycle complete→retire is not allowed).
- Allocate:
  - When alloc_count!=0, !flush, and alloc_count<=current_available: entries tail..tail+alloc_count-1 (mod NCOMMIT) get valid=1, done=0; tail += alloc_count.
  - Entries freed by retirement in the same cycle are NOT available to that cycle's allocation; current_available is the registered view.
  - alloc_count>current_available is a protocol error: the whole allocation is dropped with no state change.
- Flush:
  - Applies only if r_valid[flush_addr]; otherwise ignored entirely, and any allocation that cycle is also dropped.
  - Discards every entry strictly younger than flush_addr: valid/done cleared; tail <= flush_addr+1.
  - Allocation is ignored in a flush cycle.
  - Retirement proceeds normally in the same cycle; all retiring entries are at or older than flush_addr.
  - count_next = ((flush_addr-head) mod NCOMMIT)+1-commit_count.
- Count update, no flush: count_next = count-commit_count+alloc_accepted.
- Widths: all index arithmetic truncates to LNCOMMIT bits (wrap-around); counts use LNCOMMIT+1 bits.
- Reset asserted mid-operation wins over every other input in that cycle.
- Outputs are registered-state derived; no combinational path from alloc_count or flush to any output. A complete input affects outputs only from the next cycle.

Test Plan:
- Reset, then alloc_count=4 → next cycle next_start=4, current_available=28, empty=0, commit_done=0.
- Entries 0..3 live; complete entries 2,3 then 0 → when 0 completes, the next cycle commit_done=0x1, commit_count=1, and entry 1 blocks; complete 1 → the following cycle commit_done=0xE, commit_count=3, empty=1.
- Wrap: head=tail=30, allocate 4 → entries 30,31,0,1 valid, next_start=2; complete all → commit_done=0xC0000003 in one clock.
- Full: allocate 32 → current_available=0; then alloc_count=1 → dropped, tail unchanged; retire 1 → current_available=1 the cycle after.
- Flush: entries 0..9 live, flush_addr=5 with alloc_count=3 in the same cycle → tail=6, count=6, valid[6..9]=0, allocation ignored.
- Same cycle flush_addr=5 with entries 0,1 retiring → commit_count=2, head=2, count=4.
